// File: rtl/perf_event_counters.sv
`default_nettype none
// ============================================================================
// Module      : perf_event_counters
// Description : Cycle, committed-instruction and generic event counters with
//               halt freeze, saturation, snapshot bank and registered readout.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_event_counters #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = $clog2(NUM_CH + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic              MemWrite,
    input  logic              Halt,
    input  logic [NUM_CH-1:0] ev,
    input  logic              clear,
    input  logic              snap,
    input  logic              rd_en,
    input  logic              rd_src,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_ovf,
    output logic              halted
);

    localparam int               c_NCNT = NUM_CH + 2;
    localparam logic [CNT_W-1:0] c_MAX  = '1;

    // Counter index 0 = cycles, 1 = instructions, 2+i = event channel i
    logic [CNT_W-1:0]  r_cnt     [c_NCNT];
    logic [CNT_W-1:0]  r_shd_cnt [c_NCNT];
    logic [c_NCNT-1:0] r_ovf;
    logic [c_NCNT-1:0] r_shd_ovf;
    logic              r_halted;
    logic [c_NCNT-1:0] w_inc;

    logic [CNT_W-1:0]  r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_ovf;
    logic [CNT_W-1:0]  w_rd_data;
    logic              w_rd_ovf;

    always_comb begin
        w_inc = {ev, (Halt | RegWrite | MemWrite), 1'b1} & {c_NCNT{~r_halted}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_NCNT; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf    <= '0;
            r_halted <= 1'b0;
        end else if (clear) begin
            // Clear outranks increments and drops a coincident Halt
            for (int k = 0; k < c_NCNT; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf    <= '0;
            r_halted <= 1'b0;
        end else begin
            for (int k = 0; k < c_NCNT; k++) begin
                if (w_inc[k]) begin
                    if (r_cnt[k] == c_MAX) begin
                        r_ovf[k] <= 1'b1;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                    end
                end
            end
            if (!r_halted && Halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Shadow captures the pre-edge live values, so a snap alongside clear
    // still preserves what was counted up to this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_NCNT; k++) begin
                r_shd_cnt[k] <= '0;
            end
            r_shd_ovf <= '0;
        end else if (snap) begin
            for (int k = 0; k < c_NCNT; k++) begin
                r_shd_cnt[k] <= r_cnt[k];
            end
            r_shd_ovf <= r_ovf;
        end
    end

    // Out-of-range selects match no entry and read back as zero
    always_comb begin
        w_rd_data = '0;
        w_rd_ovf  = 1'b0;
        for (int k = 0; k < c_NCNT; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                w_rd_data = rd_src ? r_shd_cnt[k] : r_cnt[k];
                w_rd_ovf  = rd_src ? r_shd_ovf[k] : r_ovf[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_ovf   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_data;
                r_rd_ovf  <= w_rd_ovf;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_ovf   = r_rd_ovf;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_perf_event_counters.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_event_counters
// Description : Directed scoreboard bench for perf_event_counters (CNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_event_counters;

    localparam int c_NUM_CH = 4;
    localparam int c_CNT_W  = 8;
    localparam int c_SEL_W  = 3;

    logic                clk;
    logic                rst;
    logic                RegWrite;
    logic                MemWrite;
    logic                Halt;
    logic [c_NUM_CH-1:0] ev;
    logic                clear;
    logic                snap;
    logic                rd_en;
    logic                rd_src;
    logic [c_SEL_W-1:0]  rd_sel;
    logic [c_CNT_W-1:0]  rd_data;
    logic                rd_valid;
    logic                rd_ovf;
    logic                halted;

    perf_event_counters #(
        .NUM_CH (c_NUM_CH),
        .CNT_W  (c_CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Halt     (Halt),
        .ev       (ev),
        .clear    (clear),
        .snap     (snap),
        .rd_en    (rd_en),
        .rd_src   (rd_src),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ovf   (rd_ovf),
        .halted   (halted)
    );

    typedef struct packed {
        logic [c_CNT_W-1:0] d;
        logic               o;
        logic [7:0]         id;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   rd_id = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic rd(input logic src, input logic [c_SEL_W-1:0] sel,
                      input logic [c_CNT_W-1:0] d, input logic o);
        exp_t e;
        e.d  = d;
        e.o  = o;
        e.id = 8'(rd_id);
        rd_id++;
        sb.push_back(e);
        rd_en  = 1'b1;
        rd_src = src;
        rd_sel = sel;
        tick();
        rd_en  = 1'b0;
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_rd_valid: got rd_data=%0d with no read pending", rd_data);
                end else begin
                    m_e = sb.pop_front();
                    if (rd_data !== m_e.d || rd_ovf !== m_e.o) begin
                        n_err++;
                        $display("FAIL read#%0d: got data=%0d ovf=%b, expected data=%0d ovf=%b",
                                 m_e.id, rd_data, rd_ovf, m_e.d, m_e.o);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; RegWrite = 1'b0; MemWrite = 1'b0; Halt = 1'b0; ev = '0;
        clear = 1'b0; snap = 1'b0; rd_en = 1'b0; rd_src = 1'b0; rd_sel = '0;

        tick(2);
        chk("reset_rd_data", 32'(rd_data), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_rd_ovf", 32'(rd_ovf), 0);
        chk("reset_halted", 32'(halted), 0);
        rst = 1'b0;

        // Ten idle cycles after reset release
        tick(10);
        rd(1'b0, 3'd0, 8'd10, 1'b0);
        rd(1'b0, 3'd1, 8'd0, 1'b0);

        // Commit qualifiers with overlap, then Halt freezes everything
        clear = 1'b1; tick(); clear = 1'b0;
        RegWrite = 1'b1; tick(3);
        MemWrite = 1'b1; tick(2);
        RegWrite = 1'b0; tick();
        MemWrite = 1'b0; Halt = 1'b1; tick(); Halt = 1'b0;
        chk("halted_after_halt", 32'(halted), 1);
        RegWrite = 1'b1; MemWrite = 1'b1; Halt = 1'b1; ev = 4'hF;
        tick(20);
        RegWrite = 1'b0; MemWrite = 1'b0; Halt = 1'b0; ev = '0;
        rd(1'b0, 3'd0, 8'd7, 1'b0);
        rd(1'b0, 3'd1, 8'd7, 1'b0);
        rd(1'b0, 3'd2, 8'd0, 1'b0);
        rd(1'b0, 3'd5, 8'd0, 1'b0);
        chk("halted_sticky", 32'(halted), 1);

        // Clear with Halt in the same cycle drops the Halt
        clear = 1'b1; Halt = 1'b1; tick(); clear = 1'b0; Halt = 1'b0;
        chk("halted_after_clear_halt", 32'(halted), 0);
        tick(4);
        rd(1'b0, 3'd0, 8'd4, 1'b0);
        rd(1'b0, 3'd1, 8'd0, 1'b0);
        ev = 4'b1011; tick(3);
        ev = 4'b0001; tick(2);
        ev = '0;
        rd(1'b0, 3'd2, 8'd5, 1'b0);
        rd(1'b0, 3'd3, 8'd3, 1'b0);
        rd(1'b0, 3'd4, 8'd0, 1'b0);
        rd(1'b0, 3'd5, 8'd3, 1'b0);

        // Snapshot at cyc=50, live read at cyc=80
        clear = 1'b1; tick(); clear = 1'b0;
        tick(50);
        snap = 1'b1; tick(); snap = 1'b0;
        tick(29);
        rd(1'b0, 3'd0, 8'd80, 1'b0);
        rd(1'b1, 3'd0, 8'd50, 1'b0);
        snap = 1'b1; clear = 1'b1; tick(); snap = 1'b0; clear = 1'b0;
        rd(1'b0, 3'd0, 8'd0, 1'b0);
        rd(1'b1, 3'd0, 8'd82, 1'b0);
        tick();
        chk("rd_valid_idle", 32'(rd_valid), 0);
        chk("rd_data_hold", 32'(rd_data), 82);

        // Saturation boundary: 255 with no overflow, then overflow sticks
        clear = 1'b1; tick(); clear = 1'b0;
        ev = 4'b0100; tick(255); ev = '0;
        rd(1'b0, 3'd4, 8'd255, 1'b0);
        ev = 4'b0100; tick(45); ev = '0;
        rd(1'b0, 3'd4, 8'd255, 1'b1);
        rd(1'b0, 3'd0, 8'd255, 1'b1);
        rd(1'b0, 3'd2, 8'd0, 1'b0);
        rd(1'b1, 3'd4, 8'd0, 1'b0);
        clear = 1'b1; tick(); clear = 1'b0;
        rd(1'b0, 3'd4, 8'd0, 1'b0);
        rd(1'b0, 3'd0, 8'd1, 1'b0);

        // Out-of-range selects
        rd(1'b0, 3'd6, 8'd0, 1'b0);
        rd(1'b1, 3'd7, 8'd0, 1'b0);

        // Reset right after a read is issued kills the pending rd_valid
        rd_en = 1'b1; rd_src = 1'b0; rd_sel = 3'd0;
        tick();
        rd_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_kills_rd_valid", 32'(rd_valid), 0);
        chk("rst_zeroes_rd_data", 32'(rd_data), 0);
        tick(2);
        rst = 1'b0;
        tick();
        rd(1'b1, 3'd0, 8'd0, 1'b0);
        rd(1'b0, 3'd0, 8'd2, 1'b0);

        tick(2);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
